// File: rtl/ohs_boost_ctrl.sv
// Sequencer and switch controller for the level-1 boost converter model.
// Divides aclk down to the model integration strobe, runs the PWM carrier
// once per model step, ramps the applied duty on start-up and trips the
// switch open on inductor over-current.
module ohs_boost_ctrl #(
   parameter int unsigned MODEL_DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH        = 16,
   parameter int unsigned CE_DIV_WIDTH     = 16
) (
   input  logic                        aclk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [CE_DIV_WIDTH-1:0]     ce_div,
   input  logic [CNT_WIDTH-1:0]        pwm_period,
   input  logic [CNT_WIDTH-1:0]        duty,
   input  logic                        duty_load,
   input  logic [CNT_WIDTH-1:0]        ramp_step,
   input  logic [MODEL_DATA_WIDTH-1:0] il_limit,
   input  logic [MODEL_DATA_WIDTH-1:0] iL,
   input  logic                        fault_clear,
   output logic                        ce,
   output logic                        S1_pwm,
   output logic                        period_start,
   output logic [CNT_WIDTH-1:0]        duty_active,
   output logic [1:0]                  state,
   output logic                        fault
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRamp  = 2'd1,
      StRun   = 2'd2,
      StFault = 2'd3
   } state_e;

   state_e                  state_q;
   logic [CE_DIV_WIDTH-1:0] ce_cnt_q;
   logic                    ce_q;
   logic [CNT_WIDTH-1:0]    carrier_q;
   logic [CNT_WIDTH-1:0]    duty_shadow_q;
   logic [CNT_WIDTH-1:0]    duty_active_q;
   logic                    s1_q;
   logic                    fault_q;

   logic [CNT_WIDTH-1:0]    period_eff;
   logic [CNT_WIDTH-1:0]    period_last;
   logic [CNT_WIDTH-1:0]    duty_clamped;
   logic [CNT_WIDTH:0]      ramp_sum;
   logic [CNT_WIDTH-1:0]    ramp_next;
   logic                    switching;
   logic                    over_current;
   logic                    ce_wrap;
   logic                    boundary;

   // Derived carrier/duty quantities shared by the shadow and FSM logic.
   always_comb begin
      period_eff   = (pwm_period == '0) ? CNT_WIDTH'(1) : pwm_period;
      period_last  = period_eff - CNT_WIDTH'(1);
      duty_clamped = (duty > period_eff) ? period_eff : duty;
      switching    = (state_q == StRamp) || (state_q == StRun);
      over_current = $signed(iL) > $signed(il_limit);
      // >= so a divider or period lowered below the running count wraps at once
      ce_wrap      = ce_cnt_q >= ce_div;
      boundary     = ce_q && switching && (carrier_q >= period_last);
      // One extra bit so the ramp saturates instead of wrapping
      ramp_sum     = {1'b0, duty_active_q} + {1'b0, ramp_step};
      if ((ramp_step == '0) || (ramp_sum >= {1'b0, duty_shadow_q})) begin
         ramp_next = duty_shadow_q;
      end else begin
         ramp_next = ramp_sum[CNT_WIDTH-1:0];
      end
   end

   // Duty shadow: captured on duty_load, consumed only at period boundaries.
   always_ff @(posedge aclk) begin
      if (reset) begin
         duty_shadow_q <= '0;
      end else if (duty_load) begin
         duty_shadow_q <= duty_clamped;
      end
   end

   // Main sequencer: ce divider, carrier, duty application and run/fault FSM.
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q       <= StIdle;
         ce_cnt_q      <= '0;
         ce_q          <= 1'b0;
         carrier_q     <= '0;
         duty_active_q <= '0;
         s1_q          <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         // The model is frozen in IDLE; elsewhere it integrates every ce_div+1 clocks
         if (state_q == StIdle) begin
            ce_cnt_q <= '0;
            ce_q     <= 1'b0;
         end else if (ce_wrap) begin
            ce_cnt_q <= '0;
            ce_q     <= 1'b1;
         end else begin
            ce_cnt_q <= ce_cnt_q + CE_DIV_WIDTH'(1);
            ce_q     <= 1'b0;
         end

         s1_q <= switching && (carrier_q < duty_active_q);

         if ((state_q != StFault) && over_current) begin
            state_q       <= StFault;
            fault_q       <= 1'b1;
            s1_q          <= 1'b0;
            carrier_q     <= '0;
            duty_active_q <= '0;
         end else begin
            unique case (state_q)
               StFault: begin
                  carrier_q <= '0;
                  // Clearing needs the run request dropped so we never restart blindly
                  if (fault_clear && !enable) begin
                     state_q  <= StIdle;
                     fault_q  <= 1'b0;
                     ce_cnt_q <= '0;
                     ce_q     <= 1'b0;
                  end
               end
               StIdle: begin
                  if (enable) begin
                     state_q       <= StRamp;
                     duty_active_q <= '0;
                     carrier_q     <= '0;
                  end
               end
               StRamp, StRun: begin
                  if (!enable) begin
                     state_q       <= StIdle;
                     duty_active_q <= '0;
                     carrier_q     <= '0;
                     s1_q          <= 1'b0;
                     ce_cnt_q      <= '0;
                     ce_q          <= 1'b0;
                  end else if (boundary) begin
                     carrier_q <= '0;
                     if (state_q == StRamp) begin
                        duty_active_q <= ramp_next;
                        if (ramp_next == duty_shadow_q) begin
                           state_q <= StRun;
                        end
                     end else begin
                        duty_active_q <= duty_shadow_q;
                     end
                  end else if (ce_q) begin
                     carrier_q <= carrier_q + CNT_WIDTH'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign ce           = ce_q;
   assign S1_pwm       = s1_q;
   assign period_start = boundary;
   assign duty_active  = duty_active_q;
   assign state        = state_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_ohs_boost_ctrl.sv
// Scoreboard bench for ohs_boost_ctrl: the driver steps an integer reference
// model alongside each stimulus cycle and queues the expected outputs; the
// monitor pops and compares after every clock edge.
module tb_ohs_boost_ctrl;

   logic               aclk = 1'b0;
   logic               reset;
   logic               enable;
   logic [15:0]        ce_div;
   logic [15:0]        pwm_period;
   logic [15:0]        duty;
   logic               duty_load;
   logic [15:0]        ramp_step;
   logic signed [31:0] il_limit;
   logic signed [31:0] iL;
   logic               fault_clear;
   logic               ce;
   logic               S1_pwm;
   logic               period_start;
   logic [15:0]        duty_active;
   logic [1:0]         state;
   logic               fault;

   always #5 aclk = ~aclk;

   ohs_boost_ctrl #(
      .MODEL_DATA_WIDTH (32),
      .CNT_WIDTH        (16),
      .CE_DIV_WIDTH     (16)
   ) dut (
      .aclk         (aclk),
      .reset        (reset),
      .enable       (enable),
      .ce_div       (ce_div),
      .pwm_period   (pwm_period),
      .duty         (duty),
      .duty_load    (duty_load),
      .ramp_step    (ramp_step),
      .il_limit     (il_limit),
      .iL           (iL),
      .fault_clear  (fault_clear),
      .ce           (ce),
      .S1_pwm       (S1_pwm),
      .period_start (period_start),
      .duty_active  (duty_active),
      .state        (state),
      .fault        (fault)
   );

   typedef struct {
      int ce;
      int s1;
      int ps;
      int duty;
      int st;
      int fault;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state (0=IDLE 1=RAMP 2=RUN 3=FAULT)
   int m_state, m_phase, m_ce, m_carrier, m_shadow, m_duty, m_s1, m_fault;

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int peff();
      return (pwm_period == 0) ? 1 : int'(pwm_period);
   endfunction

   function automatic bit boundary_now();
      return (m_ce != 0) && (m_state == 1 || m_state == 2) && (m_carrier >= peff() - 1);
   endfunction

   task automatic model_step();
      int  pe;
      bit  act, oc, bnd;
      int  n_state, n_phase, n_ce, n_carrier, n_shadow, n_duty, n_s1, n_fault, tgt;
      exp_t e;
      pe  = peff();
      act = (m_state == 1 || m_state == 2);
      oc  = $signed(iL) > $signed(il_limit);
      bnd = boundary_now();
      if (reset) begin
         n_state = 0; n_phase = 0; n_ce = 0; n_carrier = 0;
         n_shadow = 0; n_duty = 0; n_s1 = 0; n_fault = 0;
      end else begin
         n_state = m_state; n_carrier = m_carrier; n_duty = m_duty; n_fault = m_fault;
         n_shadow = duty_load ? imin(int'(duty), pe) : m_shadow;
         n_s1 = (act && m_carrier < m_duty) ? 1 : 0;
         // ce fires on the last clock of each group of ce_div+1 non-idle clocks
         if (m_state == 0) begin
            n_phase = 0; n_ce = 0;
         end else begin
            n_ce = ((m_phase % (int'(ce_div) + 1)) == int'(ce_div)) ? 1 : 0;
            n_phase = m_phase + 1;
         end
         if (m_state != 3 && oc) begin
            n_state = 3; n_fault = 1; n_s1 = 0; n_carrier = 0; n_duty = 0;
         end else if (m_state == 3) begin
            n_carrier = 0;
            if (fault_clear && !enable) begin
               n_state = 0; n_fault = 0; n_phase = 0; n_ce = 0;
            end
         end else if (m_state == 0) begin
            if (enable) begin
               n_state = 1; n_duty = 0; n_carrier = 0;
            end
         end else if (!enable) begin
            n_state = 0; n_duty = 0; n_carrier = 0; n_s1 = 0; n_phase = 0; n_ce = 0;
         end else if (bnd) begin
            n_carrier = 0;
            if (m_state == 1) begin
               tgt = (ramp_step == 0) ? m_shadow : imin(m_duty + int'(ramp_step), m_shadow);
               n_duty = tgt;
               if (tgt == m_shadow) n_state = 2;
            end else begin
               n_duty = m_shadow;
            end
         end else if (m_ce != 0) begin
            n_carrier = m_carrier + 1;
         end
      end
      m_state = n_state; m_phase = n_phase; m_ce = n_ce; m_carrier = n_carrier;
      m_shadow = n_shadow; m_duty = n_duty; m_s1 = n_s1; m_fault = n_fault;
      e.ce    = m_ce;
      e.s1    = m_s1;
      e.ps    = boundary_now() ? 1 : 0;
      e.duty  = m_duty;
      e.st    = m_state;
      e.fault = m_fault;
      exp_q.push_back(e);
   endtask

   // Inputs for the coming edge are already set; queue its expectation and move on.
   task automatic drive_cycle();
      model_step();
      @(negedge aclk);
      duty_load = 1'b0;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) drive_cycle();
   endtask

   task automatic do_reset(input int div);
      reset  = 1'b1;
      ce_div = 16'(div);
      run_cycles(2);
      reset  = 1'b0;
   endtask

   task automatic load_duty(input int d);
      duty      = 16'(d);
      duty_load = 1'b1;
      drive_cycle();
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: every edge presents a full output snapshot.
   initial begin
      exp_t e;
      forever begin
         @(posedge aclk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ce", int'(ce), e.ce);
            check("S1_pwm", int'(S1_pwm), e.s1);
            check("period_start", int'(period_start), e.ps);
            check("duty_active", int'(duty_active), e.duty);
            check("state", int'(state), e.st);
            check("fault", int'(fault), e.fault);
         end
      end
   end

   initial begin
      bit en_level;
      bit hit;
      reset = 1'b1; enable = 1'b0; ce_div = 16'd3; pwm_period = 16'd10; duty = '0;
      duty_load = 1'b0; ramp_step = '0; il_limit = 32'sd1000; iL = 32'sd0; fault_clear = 1'b0;
      m_state = 0; m_phase = 0; m_ce = 0; m_carrier = 0;
      m_shadow = 0; m_duty = 0; m_s1 = 0; m_fault = 0;
      @(negedge aclk);

      // ce divider at 3, then frozen in IDLE
      do_reset(3);
      enable = 1'b1;
      run_cycles(20);
      enable = 1'b0;
      run_cycles(10);

      // Direct application of duty 4 with no ramp
      do_reset(0);
      pwm_period = 16'd10; ramp_step = 16'd0;
      load_duty(4);
      enable = 1'b1;
      run_cycles(40);

      // Ramp 4, 8, 9, then an over-range duty clamps to the period
      enable = 1'b0;
      do_reset(0);
      ramp_step = 16'd4;
      load_duty(9);
      enable = 1'b1;
      run_cycles(45);
      load_duty(15);
      run_cycles(25);

      // Over-current trip, ignored clear while enabled, then release
      iL = il_limit + 1;
      drive_cycle();
      iL = 32'sd0;
      run_cycles(6);
      fault_clear = 1'b1;
      run_cycles(4);
      enable = 1'b0;
      run_cycles(3);
      fault_clear = 1'b0;

      // duty_load coincident with a boundary while running at 6
      do_reset(0);
      ramp_step = 16'd0;
      load_duty(6);
      enable = 1'b1;
      run_cycles(25);
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (boundary_now()) begin
            hit = 1'b1;
            load_duty(2);
         end else begin
            drive_cycle();
         end
      end
      check("boundary_reached", int'(hit), 1);
      run_cycles(25);

      // Reset while ramping with carrier at 5, enable held high
      enable = 1'b0;
      do_reset(0);
      ramp_step = 16'd1;
      load_duty(9);
      enable = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (m_state == 1 && m_carrier == 5) hit = 1'b1;
         else drive_cycle();
      end
      check("ramp_carrier5_reached", int'(hit), 1);
      reset = 1'b1;
      drive_cycle();
      reset = 1'b0;
      run_cycles(6);

      // Randomized episodes
      for (int ep = 0; ep < 20; ep++) begin
         enable   = 1'b0;
         il_limit = $signed($urandom_range(0, 1000)) - 500;
         iL       = il_limit - 10;
         do_reset(int'($urandom_range(0, 3)));
         pwm_period = 16'($urandom_range(0, 12));
         ramp_step  = 16'($urandom_range(0, 5));
         load_duty(int'($urandom_range(0, 14)));
         en_level = 1'b1;
         for (int c = 0; c < 150; c++) begin
            if ($urandom_range(0, 49) == 0) en_level = !en_level;
            enable      = en_level;
            fault_clear = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
               duty      = 16'($urandom_range(0, 14));
               duty_load = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) pwm_period = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 99) == 0) iL = il_limit + $signed($urandom_range(0, 2));
            else iL = il_limit - $signed($urandom_range(0, 50));
            drive_cycle();
         end
         fault_clear = 1'b0;
      end

      repeat (3) @(posedge aclk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
